bomb_placer: RTL and testbench

// - Downstream of the player motion stage: consumes the player's topLeftX/Y and a bomb key.
// - Snaps the player's centre to the 32x32 arena tile grid and drops a single bomb there.
// - Runs the bomb's fuse in frames, then holds the explosion window.
// - Exposes bomb position and blast state to the drawing and collision stages.

---
 rtl/bomb_placer_pkg.sv | 17 +
 rtl/bomb_placer_if.sv | 35 +++
 rtl/bomb_placer_key_rise_det.sv | 22 ++
 rtl/bomb_placer.sv | 97 +++++++++
 tb/tb_bomb_placer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_placer_pkg.sv
// Shared arena geometry and bomb FSM state encoding.
package bomber_pkg;

  typedef enum logic [1:0] {
    IDLE_ST  = 2'd0,
    ARMED_ST = 2'd1,
    BLAST_ST = 2'd2
  } bomb_state_t;

  // Arena origin lines up with the player's left/top motion limits
  localparam int ARENA_X0   = 15;
  localparam int ARENA_Y0   = 48;
  localparam int TILE_SHIFT = 5;
  localparam int GRID_COLS  = 19;
  localparam int GRID_ROWS  = 13;

endpackage

// File: rtl/bomb_placer_if.sv
// Bomb placer bus: player/control inputs and bomb/blast outputs.
interface bomb_placer_if;

  logic               startOfFrame;
  logic               game_on;
  logic               place_key;
  logic               chain_hit;
  logic        [1:0]  fire_range;
  logic signed [10:0] playerTopLeftX;
  logic signed [10:0] playerTopLeftY;
  logic               bomb_active;
  logic signed [10:0] bombTopLeftX;
  logic signed [10:0] bombTopLeftY;
  logic               blast_active;
  logic               explode_pulse;
  logic        [1:0]  blast_range;
  logic        [6:0]  fuse_left;

  // Upstream side: drives player/control, observes the bomb
  modport master (
    output startOfFrame, game_on, place_key, chain_hit, fire_range,
           playerTopLeftX, playerTopLeftY,
    input  bomb_active, bombTopLeftX, bombTopLeftY, blast_active,
           explode_pulse, blast_range, fuse_left
  );

  // Bomb placer side
  modport slave (
    input  startOfFrame, game_on, place_key, chain_hit, fire_range,
           playerTopLeftX, playerTopLeftY,
    output bomb_active, bombTopLeftX, bombTopLeftY, blast_active,
           explode_pulse, blast_range, fuse_left
  );

endinterface

// File: rtl/bomb_placer_key_rise_det.sv
// Registered rising-edge detector for a raw key level.
module key_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic pulse_out
);

  logic level_d;

  // Keep a one-clock history of the key and flag 0->1 transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d   <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      level_d   <= level_in;
      pulse_out <= level_in & ~level_d;
    end
  end

endmodule

// File: rtl/bomb_placer.sv
// Single-bomb placer: snaps the player to the tile grid, runs fuse and blast.
module bomb_placer
  import bomber_pkg::*;
#(
  parameter int FUSE_FRAMES  = 90,
  parameter int BLAST_FRAMES = 15
) (
  input  logic         clk,
  input  logic         reset,
  bomb_placer_if.slave bus
);

  bomb_state_t        state;
  logic        [3:0]  blast_cnt;
  logic               key_edge;
  logic signed [11:0] cx, cy, col, row;
  logic signed [10:0] snap_x, snap_y;
  logic               snap_valid;

  key_rise_det u_key (
    .clk       (clk),
    .reset     (reset),
    .level_in  (bus.place_key),
    .pulse_out (key_edge)
  );

  // Player centre to tile column/row and back to the tile's top-left pixel
  always_comb begin
    cx     = 12'(signed'(bus.playerTopLeftX)) + 12'sd16 - signed'(12'(ARENA_X0));
    cy     = 12'(signed'(bus.playerTopLeftY)) + 12'sd16 - signed'(12'(ARENA_Y0));
    col    = cx >>> TILE_SHIFT;
    row    = cy >>> TILE_SHIFT;
    snap_valid = !cx[11] && !cy[11] &&
                 ($unsigned(col) < 12'(GRID_COLS)) &&
                 ($unsigned(row) < 12'(GRID_ROWS));
    snap_x = 11'(signed'(12'(ARENA_X0)) + (col <<< TILE_SHIFT));
    snap_y = 11'(signed'(12'(ARENA_Y0)) + (row <<< TILE_SHIFT));
  end

  // Bomb lifecycle FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset || !bus.game_on) begin
      state             <= IDLE_ST;
      blast_cnt         <= '0;
      bus.bomb_active   <= 1'b0;
      bus.bombTopLeftX  <= '0;
      bus.bombTopLeftY  <= '0;
      bus.blast_active  <= 1'b0;
      bus.explode_pulse <= 1'b0;
      bus.blast_range   <= '0;
      bus.fuse_left     <= '0;
    end else begin
      bus.explode_pulse <= 1'b0;
      case (state)
        IDLE_ST: begin
          if (key_edge && snap_valid) begin
            state            <= ARMED_ST;
            bus.bomb_active  <= 1'b1;
            bus.bombTopLeftX <= snap_x;
            bus.bombTopLeftY <= snap_y;
            bus.blast_range  <= (bus.fire_range == 2'd0) ? 2'd1 : bus.fire_range;
            bus.fuse_left    <= 7'(FUSE_FRAMES);
          end
        end
        ARMED_ST: begin
          // A chain hit and the last fuse frame collapse into one detonation
          if (bus.chain_hit || (bus.startOfFrame && bus.fuse_left == 7'd1)) begin
            state             <= BLAST_ST;
            bus.explode_pulse <= 1'b1;
            bus.blast_active  <= 1'b1;
            bus.fuse_left     <= '0;
            blast_cnt         <= 4'(BLAST_FRAMES);
          end else if (bus.startOfFrame) begin
            bus.fuse_left <= bus.fuse_left - 7'd1;
          end
        end
        BLAST_ST: begin
          if (bus.startOfFrame) begin
            if (blast_cnt == 4'd1) begin
              state            <= IDLE_ST;
              blast_cnt        <= '0;
              bus.bomb_active  <= 1'b0;
              bus.blast_active <= 1'b0;
              bus.blast_range  <= '0;
              bus.bombTopLeftX <= '0;
              bus.bombTopLeftY <= '0;
            end else begin
              blast_cnt <= blast_cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_placer.sv
// Directed bench for bomb_placer: placement, fuse, blast, chain, rejects, aborts.
module tb_bomb_placer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   n_exp = 0;
  int   n_place = 0;
  logic ba_prev = 1'b0;
  int   base_exp, base_place;

  bomb_placer_if bif ();

  bomb_placer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // Count detonation pulses and bomb placements between active edges
  always @(negedge clk) begin
    if (bif.explode_pulse === 1'b1) n_exp = n_exp + 1;
    if (bif.bomb_active === 1'b1 && ba_prev !== 1'b1) n_place = n_place + 1;
    ba_prev = bif.bomb_active;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bif.startOfFrame = 1'b1;
    tick();
    bif.startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_bomb_active"},   {31'd0, bif.bomb_active},   32'd0);
    chk({tag, "_blast_active"},  {31'd0, bif.blast_active},  32'd0);
    chk({tag, "_explode_pulse"}, {31'd0, bif.explode_pulse}, 32'd0);
    chk({tag, "_blast_range"},   {30'd0, bif.blast_range},   32'd0);
    chk({tag, "_fuse_left"},     {25'd0, bif.fuse_left},     32'd0);
    chk({tag, "_x"},             {21'd0, bif.bombTopLeftX},  32'd0);
    chk({tag, "_y"},             {21'd0, bif.bombTopLeftY},  32'd0);
  endtask

  task automatic chk_bomb(input string tag, input int x, input int y, input int fuse);
    chk({tag, "_bomb_active"}, {31'd0, bif.bomb_active},  32'd1);
    chk({tag, "_x"},           {21'd0, bif.bombTopLeftX}, 32'(x));
    chk({tag, "_y"},           {21'd0, bif.bombTopLeftY}, 32'(y));
    chk({tag, "_fuse_left"},   {25'd0, bif.fuse_left},    32'(fuse));
  endtask

  // Fresh key press: release, press, wait the two-clock latency
  task automatic press();
    bif.place_key = 1'b0;
    tick();
    bif.place_key = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset              = 1'b1;
    bif.startOfFrame   = 1'b0;
    bif.game_on        = 1'b0;
    bif.place_key      = 1'b0;
    bif.chain_hit      = 1'b0;
    bif.fire_range     = 2'd0;
    bif.playerTopLeftX = 11'sd15;
    bif.playerTopLeftY = 11'sd48;
    tick();
    tick();
    chk_clear("reset");
    reset       = 1'b0;
    bif.game_on = 1'b1;
    tick();
    chk_clear("idle");

    // Top-left tile, range 0 treated as 1, two-clock latency
    bif.place_key = 1'b1;
    tick();
    chk("lat1_bomb_active", {31'd0, bif.bomb_active}, 32'd0);
    tick();
    chk_bomb("p15_48", 15, 48, 90);
    chk("p15_48_range", {30'd0, bif.blast_range}, 32'd1);
    bif.game_on = 1'b0;
    tick();
    chk_clear("gameoff_armed");
    bif.game_on = 1'b1;

    // (60,100) -> tile (1,2) -> (47,112); full fuse then blast
    base_exp = n_exp;
    bif.playerTopLeftX = 11'sd60;
    bif.playerTopLeftY = 11'sd100;
    bif.fire_range     = 2'd2;
    press();
    chk_bomb("p60_100", 47, 112, 90);
    chk("p60_100_range", {30'd0, bif.blast_range}, 32'd2);
    frames(89);
    chk("fuse_last", {25'd0, bif.fuse_left}, 32'd1);
    chk("fuse_last_blast", {31'd0, bif.blast_active}, 32'd0);
    bif.startOfFrame = 1'b1;
    tick();
    bif.startOfFrame = 1'b0;
    chk("det_pulse", {31'd0, bif.explode_pulse}, 32'd1);
    chk("det_blast", {31'd0, bif.blast_active}, 32'd1);
    chk("det_fuse", {25'd0, bif.fuse_left}, 32'd0);
    tick();
    chk("det_pulse_off", {31'd0, bif.explode_pulse}, 32'd0);
    press();
    chk("blast_key_x", {21'd0, bif.bombTopLeftX}, 32'd47);
    chk("blast_key_active", {31'd0, bif.blast_active}, 32'd1);
    bif.chain_hit = 1'b1;
    tick();
    tick();
    bif.chain_hit = 1'b0;
    frames(14);
    chk("blast_14", {31'd0, bif.blast_active}, 32'd1);
    chk("blast_14_range", {30'd0, bif.blast_range}, 32'd2);
    frame();
    chk_clear("after_blast");
    chk("one_explode", 32'(n_exp - base_exp), 32'd1);
    tick();
    tick();
    chk("held_no_rearm", {31'd0, bif.bomb_active}, 32'd0);

    // Key held 200 frames places exactly one bomb
    bif.place_key = 1'b0;
    tick();
    base_exp   = n_exp;
    base_place = n_place;
    bif.place_key = 1'b1;
    frames(200);
    chk("held_places", 32'(n_place - base_place), 32'd1);
    chk("held_explodes", 32'(n_exp - base_exp), 32'd1);
    chk("held_end_active", {31'd0, bif.bomb_active}, 32'd0);

    // New edge after idle; chain hit at fuse 40
    bif.fire_range = 2'd3;
    press();
    chk_bomb("rearm", 47, 112, 90);
    chk("rearm_range", {30'd0, bif.blast_range}, 32'd3);
    frames(50);
    chk("fuse_40", {25'd0, bif.fuse_left}, 32'd40);
    base_exp = n_exp;
    bif.chain_hit = 1'b1;
    tick();
    chk("chain_pulse", {31'd0, bif.explode_pulse}, 32'd1);
    chk("chain_blast", {31'd0, bif.blast_active}, 32'd1);
    chk("chain_fuse", {25'd0, bif.fuse_left}, 32'd0);
    tick();
    chk("chain_no_repulse", {31'd0, bif.explode_pulse}, 32'd0);
    bif.chain_hit = 1'b0;
    chk("chain_count", 32'(n_exp - base_exp), 32'd1);
    bif.game_on = 1'b0;
    tick();
    chk_clear("gameoff_blast");
    bif.game_on = 1'b1;

    // Chain hit coinciding with the final fuse frame
    press();
    chk_bomb("final_arm", 47, 112, 90);
    frames(89);
    chk("final_fuse1", {25'd0, bif.fuse_left}, 32'd1);
    base_exp = n_exp;
    bif.chain_hit    = 1'b1;
    bif.startOfFrame = 1'b1;
    tick();
    bif.startOfFrame = 1'b0;
    chk("final_pulse", {31'd0, bif.explode_pulse}, 32'd1);
    tick();
    tick();
    bif.chain_hit = 1'b0;
    chk("final_count", 32'(n_exp - base_exp), 32'd1);
    chk("final_blast", {31'd0, bif.blast_active}, 32'd1);
    bif.game_on = 1'b0;
    tick();
    bif.game_on = 1'b1;

    // Reset while armed
    press();
    chk("rst_arm", {31'd0, bif.bomb_active}, 32'd1);
    reset = 1'b1;
    tick();
    chk_clear("rst_armed");
    reset = 1'b0;

    // Off-grid positions are rejected
    bif.playerTopLeftX = -11'sd20;
    bif.playerTopLeftY = 11'sd100;
    press();
    tick();
    chk("rej_negx", {31'd0, bif.bomb_active}, 32'd0);
    bif.playerTopLeftX = 11'sd60;
    bif.playerTopLeftY = 11'sd470;
    press();
    tick();
    chk("rej_row13", {31'd0, bif.bomb_active}, 32'd0);

    // Bottom-right valid tile (18,12)
    bif.playerTopLeftX = 11'sd591;
    bif.playerTopLeftY = 11'sd432;
    press();
    chk_bomb("corner", 591, 432, 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
